xwys_div_16: RTL and testbench
==============================

XWYS_DIV_16 -- requirements
Module: xwys_div_16

Interface
REQ-001 SHALL have no parameters; DIVIDEND_W=32, DIVISOR_W=16 and ITER_N=32 come from the shared package.
REQ-002 SHALL use one clock and a synchronous, active-high reset, in the port order below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dividend  input  32  signed two's-complement dividend (a 16x16 signed product).
REQ-008 divisor  input  16  signed two's-complement divisor.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 q  output  16  signed quotient.
REQ-012 r  output  16  signed remainder.
REQ-013 ovf  output  1  true quotient not representable in 16-bit signed.
REQ-014 dz  output  1  divisor was zero.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-017 Acceptance (in_valid&in_ready at edge N) SHALL latch the operand signs and 32-bit magnitudes and enter CALC.
REQ-018 CALC SHALL run exactly 32 restoring-division iterations (one per cycle, 33-bit partial remainder, counter 0..31), then enter FIX.
REQ-019 FIX SHALL apply signs: truncate toward zero, remainder sign equals dividend sign, q/r registered, then enter DONE.
REQ-020 out_valid SHALL first be 1 at edge N+34 and SHALL hold q/r/ovf/dz stable until out_valid&out_ready.
REQ-021 At the handshake edge the block SHALL return to IDLE, with no back-to-back acceptance in the same cycle.
REQ-022 Latency SHALL be 34 cycles for all operands, including divide-by-zero.
REQ-023 ovf SHALL be 1 iff the signed 33-bit true quotient lies outside [-32768, 32767].
REQ-024 |r| SHALL always be < |divisor|, so r never overflows.
REQ-025 dz=1 SHALL force ovf=0, q=16'h7FFF (dividend>=0) or 16'h8000 (dividend<0), r=dividend[15:0], irrespective of the macro.
REQ-026 -2^31 / -1 SHALL produce a magnitude of 2^31 and ovf=1.

Reset
REQ-027 rst SHALL force IDLE, in_ready=1, out_valid=0, q=0, r=0, ovf=0, dz=0 at the next edge.
REQ-028 rst SHALL abort a CALC/FIX/DONE operation in progress; no result SHALL be emitted for it.
REQ-029 rst SHALL override simultaneous in_valid or out_ready.

Configuration
REQ-030 XWYS_DIV_SAT_EN defined: on ovf, q SHALL saturate to 16'h7FFF (positive true quotient) or 16'h8000 (negative); r SHALL remain the exact remainder.
REQ-031 XWYS_DIV_SAT_EN undefined: on ovf, q SHALL be the low 16 bits of the true two's-complement quotient; ovf is still reported.

Structure
REQ-032 The shared package xwys_pkg SHALL hold DIVIDEND_W, DIVISOR_W, ITER_N and the state enum type.
REQ-033 One combinational sub-module xwys_div_step SHALL hold a single restoring iteration (shift, trial subtract, quotient bit), instantiated once and reused per cycle.

Verification
REQ-034 32'h0000_0064 / 16'h0007 -> q=16'h000E, r=16'h0002, ovf=0, dz=0, out_valid at N+34.
REQ-035 32'hFFFF_FF9C (-100) / 7 -> q=16'hFFF2, r=16'hFFFE.
REQ-036 32'h8000_0000 / 16'hFFFF -> ovf=1; q=16'h7FFF with SAT_EN, q=16'h0000 without; r=0.
REQ-037 32'h0000_4000 / 0 -> dz=1, q=16'h7FFF, r=16'h4000, ovf=0.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; one cycle of out_ready -> IDLE next edge.
REQ-039 Assert rst at iteration 10 -> next edge IDLE, out_valid=0; a fresh 100/7 then completes correctly.

Source files
------------

// File: rtl/xwys_pkg.sv
// Shared widths, iteration count and FSM state type for the xwys 32/16 signed divider.
package xwys_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER_N     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; -2^31 maps to 2^31 when the result is read as unsigned.
    function automatic logic [DIVIDEND_W-1:0] mag32(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/xwys_div_step.sv
// One restoring-division iteration: shift the next dividend bit in, trial subtract, emit quotient bit.
module xwys_div_step
    import xwys_pkg::*;
(
    input  logic [DIVIDEND_W:0]   rem_in,
    input  logic [DIVIDEND_W-1:0] quo_in,
    input  logic [DIVIDEND_W-1:0] dvs,
    output logic [DIVIDEND_W:0]   rem_out,
    output logic [DIVIDEND_W-1:0] quo_out
);

    logic [DIVIDEND_W+1:0] shifted;
    logic [DIVIDEND_W+1:0] trial;

    always_comb begin
        shifted = {rem_in, quo_in[DIVIDEND_W-1]};
        trial   = shifted - {2'b00, dvs};
        // Borrow out of the top bit means the divisor did not fit: restore.
        if (!trial[DIVIDEND_W+1]) begin
            rem_out = trial[DIVIDEND_W:0];
            quo_out = {quo_in[DIVIDEND_W-2:0], 1'b1};
        end else begin
            rem_out = shifted[DIVIDEND_W:0];
            quo_out = {quo_in[DIVIDEND_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/xwys_div_16.sv
// Sequential signed 32/16 divider with 34-cycle fixed latency and valid/ready handshakes.
// Define XWYS_DIV_SAT_EN to saturate q on overflow instead of wrapping to the low 16 bits.
module xwys_div_16
    import xwys_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  q,
    output logic [DIVISOR_W-1:0]  r,
    output logic                  ovf,
    output logic                  dz
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_N - 1);

    state_t                state;
    logic [4:0]            cnt;
    logic [DIVIDEND_W:0]   rem;
    logic [DIVIDEND_W:0]   rem_nx;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVIDEND_W-1:0] quo_nx;
    logic [DIVIDEND_W-1:0] dvs_mag;
    logic                  sd;
    logic                  ss;
    logic                  dvs_zero;
    logic [DIVISOR_W-1:0]  dvd_lo;

    logic                  q_neg;
    logic [DIVIDEND_W:0]   q_true;
    logic                  ovf_fix;
    logic [DIVISOR_W-1:0]  r_mag;
    logic [DIVISOR_W-1:0]  r_fix;
    logic [DIVISOR_W-1:0]  q_fix;

    assign in_ready = (state == ST_IDLE);

    xwys_div_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvs     (dvs_mag),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Sign application; remainder magnitude is below |divisor| <= 2^15 so 16 bits hold it.
    always_comb begin
        q_neg   = sd ^ ss;
        q_true  = q_neg ? ((DIVIDEND_W+1)'(0) - {1'b0, quo}) : {1'b0, quo};
        ovf_fix = q_neg ? (quo > 32'd32768) : (quo > 32'd32767);
        r_mag   = rem[DIVISOR_W-1:0];
        r_fix   = sd ? (16'd0 - r_mag) : r_mag;
`ifdef XWYS_DIV_SAT_EN
        q_fix   = ovf_fix ? (q_neg ? 16'h8000 : 16'h7FFF) : q_true[DIVISOR_W-1:0];
`else
        q_fix   = q_true[DIVISOR_W-1:0];
`endif
        if (dvs_zero) begin
            q_fix   = sd ? 16'h8000 : 16'h7FFF;
            r_fix   = dvd_lo;
            ovf_fix = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs_mag   <= '0;
            sd        <= 1'b0;
            ss        <= 1'b0;
            dvs_zero  <= 1'b0;
            dvd_lo    <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sd       <= dividend[DIVIDEND_W-1];
                        ss       <= divisor[DIVISOR_W-1];
                        quo      <= mag32(dividend);
                        dvs_mag  <= mag32({{(DIVIDEND_W-DIVISOR_W){divisor[DIVISOR_W-1]}}, divisor});
                        dvs_zero <= (divisor == '0);
                        dvd_lo   <= dividend[DIVISOR_W-1:0];
                        rem      <= '0;
                        cnt      <= '0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    q     <= q_fix;
                    r     <= r_fix;
                    ovf   <= ovf_fix;
                    dz    <= dvs_zero;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    // out_valid rises one cycle after the registered result lands.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xwys_div_16.sv
// Directed-vector bench for xwys_div_16: table of operands, plus hold, reset-abort and reset sequences.
module tb_xwys_div_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dz;

    int checks = 0;
    int errors = 0;

`ifdef XWYS_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] eq;
        logic [15:0] er;
        logic        eovf;
        logic        edz;
    } vec_t;

    vec_t tv[16];

    xwys_div_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accepts one operation and waits for out_valid; leaves the DUT in DONE with the result shown.
    task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs,
                         output logic [15:0] gq, output logic [15:0] gr,
                         output logic govf, output logic gdz, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: must be ignored outside IDLE.
        dividend = 32'h1234_5678;
        divisor  = 16'h0003;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        gq = q; gr = r; govf = ovf; gdz = dz;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] gq, gr;
    logic        govf, gdz;
    int          lat;
    logic        seen;

    initial begin
        tv[0]  = '{32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0};
        tv[1]  = '{32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        tv[2]  = '{32'h0000_0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
        tv[3]  = '{32'hFFFF_FF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
        tv[4]  = '{32'h8000_0000, 16'hFFFF, SAT ? 16'h7FFF : 16'h0000, 16'h0000, 1'b1, 1'b0};
        tv[5]  = '{32'h0000_4000, 16'h0000, 16'h7FFF, 16'h4000, 1'b0, 1'b1};
        tv[6]  = '{32'hFFFF_C000, 16'h0000, 16'h8000, 16'hC000, 1'b0, 1'b1};
        tv[7]  = '{32'h0000_7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};
        tv[8]  = '{32'h0000_8000, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 16'h0000, 1'b1, 1'b0};
        tv[9]  = '{32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
        tv[10] = '{32'hFFFF_7FFF, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 16'h0000, 1'b1, 1'b0};
        tv[11] = '{32'h4000_0000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
        tv[12] = '{32'h4000_0000, 16'h7FFF, SAT ? 16'h7FFF : 16'h8001, 16'h0001, 1'b1, 1'b0};
        tv[13] = '{32'h0000_0007, 16'h0064, 16'h0000, 16'h0007, 1'b0, 1'b0};
        tv[14] = '{32'hFFFF_FFF9, 16'h0064, 16'h0000, 16'hFFF9, 1'b0, 1'b0};
        tv[15] = '{32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0};

        // Reset with in_valid and out_ready asserted: reset must win.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        dividend = 32'd100; divisor = 16'd7;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, q, r, ovf, dz}, {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0});
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {in_ready, out_valid}, 2'b10);

        for (int i = 0; i < 16; i++) begin
            do_op(tv[i].dvd, tv[i].dvs, gq, gr, govf, gdz, lat);
            check($sformatf("latency[%0d]", i), 64'(lat), 64'd34);
            check($sformatf("q[%0d]", i), gq, tv[i].eq);
            check($sformatf("r[%0d]", i), gr, tv[i].er);
            check($sformatf("ovf_dz[%0d]", i), {govf, gdz}, {tv[i].eovf, tv[i].edz});
            finish_op();
            check($sformatf("handshake_idle[%0d]", i), {in_ready, out_valid}, 2'b10);
        end

        // Back-pressure: result must sit still for 5 cycles with in_ready low.
        do_op(32'h0000_0064, 16'h0007, gq, gr, govf, gdz, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold[%0d]", c), {out_valid, in_ready, q, r, ovf, dz},
                  {1'b1, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0});
        end
        finish_op();
        check("hold_release", {in_ready, out_valid}, 2'b10);

        // Abort at iteration 10 (counter 10 executes on edge N+11).
        dividend = 32'h0000_0064; divisor = 16'h0007; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("abort_state", {in_ready, out_valid, q, r}, {1'b1, 1'b0, 16'h0, 16'h0});
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);

        do_op(32'h0000_0064, 16'h0007, gq, gr, govf, gdz, lat);
        check("post_abort_lat", 64'(lat), 64'd34);
        check("post_abort_res", {gq, gr, govf, gdz}, {16'h000E, 16'h0002, 1'b0, 1'b0});
        finish_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
